mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator-side load/store engine that drives the byte-addressed, big-endian `memory` block on behalf of the pipeline MEM stage.
- Accepts one request at a time over a valid/ready handshake and runs a single memory access cycle.
- Returns read data sign- or zero-extended, or an error flag.
- Rejects out-of-range or illegal-size requests without touching memory.

Parameters:
- MEM_BASE, 32'h80020000, lowest legal byte address.
- MEM_SIZE, 32'h00100000, number of legal bytes starting at MEM_BASE.

Ports:
- clk  input  1  clock; all flops are rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  sign-extend load data (ignored for word and for stores).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  request rejected; memory untouched.
- mem_address  output  32  to memory address.
- mem_data_in  output  32  to memory data_in.
- mem_write  output  1  to memory write.
- mem_access_size  output  2  to memory access_size.
- mem_data_out  input  32  from memory data_out, right-aligned.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_write=0; mem_address=0; mem_data_in=0; mem_access_size=0.
- Reset mid-operation: the in-flight request is discarded. mem_write drops immediately, without waiting for clk.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch the request and check it.
  - Legal request (size!=11, addr>=MEM_BASE, addr+bytes-1 <= MEM_BASE+MEM_SIZE-1, where bytes is 1, 2 or 4): register mem_* outputs and go to ACCESS.
  - Illegal request: set resp_err=1, resp_rdata=0, and go directly to RESP. No memory cycle occurs.
- ACCESS (exactly 1 cycle):
  - mem_address, mem_access_size and mem_data_in are stable for the whole cycle.
  - mem_write=req_write only in this state; it is 0 in all other states.
  - Memory acts on the falling edge mid-cycle.
  - For loads, mem_data_out is sampled at the rising edge ending ACCESS.
  - That edge registers the extended data into resp_rdata and moves to RESP.
- RESP:
  - resp_valid=1 and req_ready=0.
  - resp_rdata and resp_err are held until a rising edge with resp_ready=1.
  - That edge clears resp_valid and resp_err and returns to IDLE.
  - A new request cannot be accepted on the same edge.
- Latency:
  - Legal request accepted at edge E: resp_valid is high from E+2 onward.
  - Illegal request accepted at edge E: resp_valid is high from E+1 onward.
  - Throughput is at most one request per 3 cycles (2 for errors).
- Extension rules:
  - byte: bits [31:8] = req_signed ? replicate mem_data_out[7] : 0.
  - half: bits [31:16] = req_signed ? replicate mem_data_out[15] : 0.
  - word: no extension.
  - Bits of mem_data_out above the access size are ignored.
- Stores: resp_rdata=0 and resp_err=0 on success.
- Address arithmetic is 33-bit, so the end-address check does not wrap near 32'hFFFFFFFF. Addresses below MEM_BASE are errors.
- Idle mem_address and mem_access_size hold their last values. Only mem_write is forced low.

Optional Feature:
- Macro MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]!=0 or a word access with addr[1:0]!=0 is an error. It takes the illegal-request path: resp_err=1, no ACCESS cycle.
- Undefined: no alignment check. Misaligned addresses pass to memory unchanged and memory handles the byte lanes.

Test Plan:
- Word store then load: store 32'hDEADBEEF at 32'h80020000, then load word from the same address. Expect mem_write high for exactly 1 cycle, resp_rdata=32'hDEADBEEF, resp_err=0, resp_valid at E+2.
- Signed/unsigned byte loads: memory holds byte 8'h80 at 32'h80020003. Byte load with req_signed=1 gives 32'hFFFF_FF80; with req_signed=0 it gives 32'h0000_0080.
- Range error: load word at 32'h8011FFFE (crosses the end) and store byte at 32'h8001FFFF. Each gives resp_err=1 one cycle after acceptance, mem_write never asserted, resp_rdata=0.
- Backpressure: hold resp_ready=0 for 5 cycles after a half load of 16'h7FFF. resp_valid and resp_rdata=32'h00007FFF stay stable, req_ready=0 throughout, and a queued req_valid is not accepted until the cycle after the handshake.
- Async reset mid-ACCESS of a store: assert rst_n=0 between edges. mem_write falls immediately, all outputs return to reset values, and the target bytes are unchanged.
- With MEM_ACCESS_ALIGN_CHECK_EN: word load at 32'h80020002 gives resp_err=1 and no memory access. Without the macro, the same request completes with resp_err=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator-side load/store engine for the big-endian
// byte-addressed memory block. One request at a time: IDLE accepts and
// checks a request, ACCESS runs exactly one memory cycle, RESP holds the
// response until the consumer takes it.
// Optional build macro: MEM_ACCESS_ALIGN_CHECK_EN. When it is defined,
// misaligned half/word requests are rejected as errors. Otherwise they
// are passed to memory unchanged.
module mem_access_unit #(
  parameter logic [31:0] MEM_BASE = 32'h80020000,
  parameter logic [31:0] MEM_SIZE = 32'h00100000
) (
  input  logic        clk,
  input  logic        rst_n,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // memory side
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  // Attributes of the accepted request that are needed after acceptance.
  logic        write_reg;
  logic        signed_reg;
  logic [1:0]  size_reg;

  // Registered memory-side outputs.
  logic [31:0] mem_address_reg;
  logic [31:0] mem_data_in_reg;
  logic [1:0]  mem_access_size_reg;
  logic        mem_write_reg;

  // Registered response.
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  // Request legality
  logic [32:0] req_bytes;
  logic [32:0] req_first;
  logic [32:0] req_last;
  logic [32:0] region_lo;
  logic [32:0] region_hi;
  logic        size_ok;
  logic        range_ok;
  logic        align_ok;
  logic        req_legal;
  logic        accept;

  // Load extension
  logic [31:0] load_ext;

  // Legality check on the incoming request. The arithmetic is 33 bits
  // wide so an access that starts near 32'hFFFFFFFF cannot wrap back
  // into the legal window.
  always_comb begin
    req_bytes = 33'd4;
    case (req_size)
      2'b00:   req_bytes = 33'd1;
      2'b01:   req_bytes = 33'd2;
      default: req_bytes = 33'd4;
    endcase
    region_lo = {1'b0, MEM_BASE};
    region_hi = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - 33'd1;
    req_first = {1'b0, req_addr};
    req_last  = req_first + req_bytes - 33'd1;
    size_ok   = (req_size != 2'b11);
    range_ok  = (req_first >= region_lo) && (req_last <= region_hi);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    align_ok  = !((req_size == 2'b01) && req_addr[0]) &&
                !((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    align_ok  = 1'b1;
`endif
    req_legal = size_ok && range_ok && align_ok;
  end

  assign accept = (state_reg == IDLE) && req_valid;

  // Extend right-aligned memory data to 32 bits. Lanes above the access
  // size are ignored.
  always_comb begin
    load_ext = mem_data_out;
    case (size_reg)
      2'b00:   load_ext = {{24{signed_reg & mem_data_out[7]}},  mem_data_out[7:0]};
      2'b01:   load_ext = {{16{signed_reg & mem_data_out[15]}}, mem_data_out[15:0]};
      default: load_ext = mem_data_out;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_legal ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture and memory-side registers. Address, size and data
  // hold their last values when idle; only the write strobe is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg           <= 1'b0;
      signed_reg          <= 1'b0;
      size_reg            <= 2'b00;
      mem_address_reg     <= 32'd0;
      mem_data_in_reg     <= 32'd0;
      mem_access_size_reg <= 2'b00;
      mem_write_reg       <= 1'b0;
    end else begin
      if (accept && req_legal) begin
        write_reg           <= req_write;
        signed_reg          <= req_signed;
        size_reg            <= req_size;
        mem_address_reg     <= req_addr;
        mem_data_in_reg     <= req_wdata;
        mem_access_size_reg <= req_size;
        mem_write_reg       <= req_write;
      end else if (state_reg == ACCESS) begin
        mem_write_reg       <= 1'b0;
      end
    end
  end

  // Response registers: error on rejection, extended data at the end of
  // the memory cycle, error cleared when the consumer takes the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            resp_err_reg <= !req_legal;
            if (!req_legal) begin
              resp_rdata_reg <= 32'd0;
            end
          end
        end
        ACCESS: begin
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= write_reg ? 32'd0 : load_ext;
        end
        RESP: begin
          if (resp_ready) begin
            resp_err_reg <= 1'b0;
          end
        end
        default: begin
          resp_err_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address     = mem_address_reg;
  assign mem_data_in     = mem_data_in_reg;
  assign mem_access_size = mem_access_size_reg;
  assign mem_write       = mem_write_reg;
  assign resp_rdata      = resp_rdata_reg;
  assign resp_err        = resp_err_reg;

endmodule
